// File: rtl/poly_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : poly_arith_pkg
// Description : Shared ML-KEM polynomial-arithmetic types and constants.
// Revision    : 1.0 - initial release
// ============================================================================
package poly_arith_pkg;

    localparam int Q         = 3329;
    localparam int COEFF_W   = 12;
    localparam int N_DEFAULT = 256;

    typedef logic [COEFF_W-1:0] coeff_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/poly_sub_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : poly_sub_ctrl_if
// Description : Scheduler handshake and coefficient-RAM bus of poly_sub_ctrl.
//               range_err_o exists only when POLY_SUB_RANGE_CHK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface poly_sub_ctrl_if #(
    parameter int ADDR_W = 8
);
    import poly_arith_pkg::*;

    logic              start_i;
    logic              hold_i;
    logic              busy_o;
    logic              done_o;
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    coeff_t            rd_a_data_i;
    coeff_t            rd_b_data_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    coeff_t            wr_data_o;
`ifdef POLY_SUB_RANGE_CHK_EN
    logic              range_err_o;
`endif

    modport slave (
        input  start_i, hold_i, rd_a_data_i, rd_b_data_i,
`ifdef POLY_SUB_RANGE_CHK_EN
        output range_err_o,
`endif
        output busy_o, done_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o
    );

    modport master (
        output start_i, hold_i, rd_a_data_i, rd_b_data_i,
`ifdef POLY_SUB_RANGE_CHK_EN
        input  range_err_o,
`endif
        input  busy_o, done_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o
    );

endinterface
`default_nettype wire

// File: rtl/poly_sub_ctrl_mod_sub.sv
`default_nettype none
// ============================================================================
// Module      : mod_sub
// Description : Combinational r = (a - b) mod Q for operands in [0, Q-1].
// Revision    : 1.0 - initial release
// ============================================================================
module mod_sub
    import poly_arith_pkg::*;
(
    input  coeff_t i_a,
    input  coeff_t i_b,
    output coeff_t o_r
);

    localparam coeff_t c_Q = coeff_t'(Q);

    logic [COEFF_W:0] w_diff;

    // A borrow means the true difference is in [-(Q-1), -1]; adding Q in
    // COEFF_W-bit arithmetic lands it back in [1, Q-1].
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    assign o_r    = w_diff[COEFF_W] ? (w_diff[COEFF_W-1:0] + c_Q) : w_diff[COEFF_W-1:0];

endmodule
`default_nettype wire

// File: rtl/poly_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : poly_sub_ctrl
// Description : Sequences r[k] = (a[k] - b[k]) mod Q over N coefficients with
//               a two-stage read/compute/write pipeline and a freeze input.
//               Optional macro POLY_SUB_RANGE_CHK_EN adds sticky range_err_o.
// Revision    : 1.0 - initial release
// ============================================================================
module poly_sub_ctrl
    import poly_arith_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int ADDR_W = 8
)(
    input  logic           clk,
    input  logic           rst,
    poly_sub_ctrl_if.slave bus
);

    localparam logic [ADDR_W:0]   c_LAST_CNT  = (ADDR_W+1)'(N-1);
    localparam logic [ADDR_W:0]   c_CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(N-1);

    ctrl_state_e       r_state;
    ctrl_state_e       w_state_nxt;
    logic              w_rd_en;
    logic              w_start_acc;
    logic [ADDR_W-1:0] w_rd_addr;
    coeff_t            w_diff;

    // Counter carries one extra bit so N == 2**ADDR_W never wraps to 0.
    logic [ADDR_W:0]   r_cnt;
    logic              r_s1_vld;
    logic [ADDR_W-1:0] r_s1_addr;
    logic              r_wr_vld;
    logic [ADDR_W-1:0] r_wr_addr;
    coeff_t            r_wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_start_acc = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start_i) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!bus.hold_i) begin
                    w_rd_en = 1'b1;
                    if (r_cnt == c_LAST_CNT) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!bus.hold_i && r_wr_vld && (r_wr_addr == c_LAST_ADDR)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_rd_addr = w_rd_en ? r_cnt[ADDR_W-1:0] : '0;

    mod_sub u_mod_sub (
        .i_a (bus.rd_a_data_i),
        .i_b (bus.rd_b_data_i),
        .o_r (w_diff)
    );

    // Every pipeline stage freezes together on hold so a stalled write is
    // replayed with the same address and data once hold drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_addr <= '0;
            r_wr_vld  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            if (w_start_acc) begin
                r_cnt <= '0;
            end else if (w_rd_en) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
            if (!bus.hold_i) begin
                r_s1_vld  <= w_rd_en;
                r_s1_addr <= w_rd_addr;
                r_wr_vld  <= r_s1_vld;
                r_wr_addr <= r_s1_addr;
                r_wr_data <= w_diff;
            end
        end
    end

`ifdef POLY_SUB_RANGE_CHK_EN
    localparam coeff_t c_Q = coeff_t'(Q);

    logic r_range_err;
    logic w_op_bad;

    assign w_op_bad = (bus.rd_a_data_i >= c_Q) || (bus.rd_b_data_i >= c_Q);

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_range_err <= 1'b0;
        end else if (r_s1_vld && !bus.hold_i && w_op_bad) begin
            r_range_err <= 1'b1;
        end
    end

    assign bus.range_err_o = r_range_err;
`endif

    assign bus.busy_o    = (r_state != IDLE);
    assign bus.done_o    = (r_state == DONE);
    assign bus.rd_en_o   = w_rd_en;
    assign bus.rd_addr_o = w_rd_addr;
    assign bus.wr_en_o   = r_wr_vld && !bus.hold_i;
    assign bus.wr_addr_o = r_wr_addr;
    assign bus.wr_data_o = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_poly_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_poly_sub_ctrl
// Description : Self-checking bench for poly_sub_ctrl with RAM models and a
//               transaction-level reference of the expected write stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_sub_ctrl;
    import poly_arith_pkg::*;

    localparam int TB_N      = 256;
    localparam int TB_ADDR_W = 8;

    logic clk;
    logic rst;

    poly_sub_ctrl_if #(.ADDR_W(TB_ADDR_W)) bus ();

    poly_sub_ctrl #(.N(TB_N), .ADDR_W(TB_ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int mem_a [TB_N];
    int mem_b [TB_N];
    int mem_r [TB_N];

    // Synchronous-read RAMs: output register only updates on a read strobe.
    always @(posedge clk) begin
        if (bus.rd_en_o) begin
            bus.rd_a_data_i <= 12'(mem_a[bus.rd_addr_o]);
            bus.rd_b_data_i <= 12'(mem_b[bus.rd_addr_o]);
        end
    end

    int nchecks = 0;
    int nerrors = 0;
    int cyc     = 0;

    bit m_busy    = 1'b0;
    bit m_rst_chk = 1'b0;
    bit m_rerr    = 1'b0;
    int m_widx    = 0;
    int m_done_at = 0;
    int m_start_cyc = 0;
    int m_last_lat  = 0;

    function automatic int ref_sub(int a, int b);
        return ((a - b) % Q + Q) % Q;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a run accepted in cycle c yields writes 0..N-1 in order and a
    // done pulse at c+N+3, pushed out by one cycle for each held busy cycle.
    always @(negedge clk) begin
        if (m_rst_chk) begin
            chk("rst_busy",    int'(bus.busy_o),    0);
            chk("rst_done",    int'(bus.done_o),    0);
            chk("rst_rd_en",   int'(bus.rd_en_o),   0);
            chk("rst_rd_addr", int'(bus.rd_addr_o), 0);
            chk("rst_wr_en",   int'(bus.wr_en_o),   0);
            chk("rst_wr_addr", int'(bus.wr_addr_o), 0);
            chk("rst_wr_data", int'(bus.wr_data_o), 0);
`ifdef POLY_SUB_RANGE_CHK_EN
            chk("rst_range_err", int'(bus.range_err_o), 0);
`endif
            m_rst_chk = 1'b0;
        end
        chk("busy", int'(bus.busy_o), int'(m_busy));
        chk("done", int'(bus.done_o), int'(m_busy && (cyc == m_done_at)));
        if (bus.hold_i) begin
            chk("hold_wr_en", int'(bus.wr_en_o), 0);
            chk("hold_rd_en", int'(bus.rd_en_o), 0);
        end
        if (bus.rd_en_o) begin
            chk("rd_addr_in_range", int'(int'(bus.rd_addr_o) < TB_N), 1);
        end
        if (bus.wr_en_o) begin
            chk("wr_expected", int'(m_busy && (m_widx < TB_N)), 1);
            chk("wr_addr", int'(bus.wr_addr_o), m_widx);
            if (m_widx < TB_N) begin
                if ((mem_a[m_widx] < Q) && (mem_b[m_widx] < Q)) begin
                    chk("wr_data", int'(bus.wr_data_o), ref_sub(mem_a[m_widx], mem_b[m_widx]));
                end else begin
                    m_rerr = 1'b1;
                end
            end
            mem_r[bus.wr_addr_o] = int'(bus.wr_data_o);
            m_widx++;
        end
`ifdef POLY_SUB_RANGE_CHK_EN
        chk("range_err", int'(bus.range_err_o), int'(m_rerr));
`endif
        if (rst) begin
            m_busy    = 1'b0;
            m_rst_chk = 1'b1;
            m_rerr    = 1'b0;
        end else if (m_busy) begin
            if (cyc == m_done_at) begin
                m_busy     = 1'b0;
                m_last_lat = cyc - m_start_cyc;
                chk("wr_count", m_widx, TB_N);
            end else if (bus.hold_i) begin
                m_done_at++;
            end
        end else if (bus.start_i) begin
            m_busy      = 1'b1;
            m_widx      = 0;
            m_start_cyc = cyc;
            m_done_at   = cyc + TB_N + 3;
            m_rerr      = 1'b0;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_r();
        for (int i = 0; i < TB_N; i++) mem_r[i] = -1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < TB_N; i++) begin
            mem_a[i] = int'($urandom_range(0, Q - 1));
            mem_b[i] = int'($urandom_range(0, Q - 1));
        end
    endtask

    task automatic run_poly(input bit hold_en, input bit busy_pokes, input int abort_at);
        int k;
        clear_r();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        k = 0;
        while (m_busy && (k < 4000)) begin
            bus.hold_i  = hold_en && ($urandom_range(0, 4) == 0);
            bus.start_i = busy_pokes && ((k == 4) || (k == 99));
            rst         = (abort_at >= 0) && (m_widx >= abort_at);
            tick();
            k++;
        end
        rst         = 1'b0;
        bus.hold_i  = 1'b0;
        bus.start_i = 1'b0;
        if (k >= 4000) begin
            nchecks++;
            nerrors++;
            $display("FAIL run_timeout: got busy after %0d cycles expected idle", k);
        end
    endtask

    task automatic check_final_r();
        int bad;
        bad = 0;
        for (int i = 0; i < TB_N; i++) begin
            if (mem_r[i] != ref_sub(mem_a[i], mem_b[i])) bad++;
        end
        chk("final_r_mismatches", bad, 0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.start_i     = 1'b0;
        bus.hold_i      = 1'b0;
        bus.rd_a_data_i = '0;
        bus.rd_b_data_i = '0;
        for (int i = 0; i < TB_N; i++) begin
            mem_a[i] = 0;
            mem_b[i] = 0;
            mem_r[i] = -1;
        end
        tick();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        rst = 1'b0;
        repeat (3) tick();

        // Basic ramp: r[k] = (k - 2k) mod Q
        for (int i = 0; i < TB_N; i++) begin
            mem_a[i] = i;
            mem_b[i] = (2 * i) % Q;
        end
        run_poly(1'b0, 1'b0, -1);
        chk("latency_no_hold", m_last_lat, 259);
        chk("basic_r0",   mem_r[0],   0);
        chk("basic_r1",   mem_r[1],   3328);
        chk("basic_r128", mem_r[128], 3201);
        chk("basic_r255", mem_r[255], 3074);
        repeat (2) tick();

        // Arithmetic boundaries
        fill_random();
        mem_a[0] = 0;    mem_b[0] = 1;
        mem_a[1] = 3328; mem_b[1] = 0;
        mem_a[2] = 0;    mem_b[2] = 3328;
        mem_a[3] = 100;  mem_b[3] = 100;
        mem_a[255] = 3328; mem_b[255] = 3328;
        run_poly(1'b0, 1'b0, -1);
        chk("bnd_0_minus_1",    mem_r[0], 3328);
        chk("bnd_3328_minus_0", mem_r[1], 3328);
        chk("bnd_0_minus_3328", mem_r[2], 1);
        chk("bnd_equal",        mem_r[3], 0);
        chk("bnd_last_equal",   mem_r[255], 0);
        repeat (2) tick();

        // Random hold pattern
        fill_random();
        run_poly(1'b1, 1'b0, -1);
        check_final_r();
        tick();

        // Start while busy is ignored; back-to-back start right after done
        fill_random();
        run_poly(1'b0, 1'b1, -1);
        check_final_r();
        run_poly(1'b1, 1'b0, -1);
        check_final_r();
        repeat (2) tick();

        // Reset mid-run, then a clean run
        fill_random();
        run_poly(1'b0, 1'b0, 128);
        repeat (10) tick();
        fill_random();
        run_poly(1'b0, 1'b0, -1);
        check_final_r();
        chk("latency_after_abort", m_last_lat, 259);
        repeat (2) tick();

`ifdef POLY_SUB_RANGE_CHK_EN
        fill_random();
        mem_a[7] = 3400;
        run_poly(1'b0, 1'b0, -1);
        repeat (3) tick();
        chk("range_err_sticky", int'(bus.range_err_o), 1);
        fill_random();
        run_poly(1'b0, 1'b0, -1);
        chk("range_err_cleared", int'(bus.range_err_o), 0);
        repeat (2) tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
`default_nettype wire
